// File: rtl/uart_rx_fifo_pkg.sv
`timescale 1ns/1ps
// Constants shared by the UART receive and transmit paths: FSM state encodings and byte width.
package uart_rx_fifo_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_rx_fifo_byte_fifo.sv
`timescale 1ns/1ps
// Show-ahead FIFO: head visible combinationally, write lands 1 clk after wr_en.
// No backpressure on wr_en; writes while full are dropped unless a pop happens in the same clk.
module byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Extra pointer MSB separates "wrapped once" (full) from "same lap" (empty).
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = rd_en && !empty;
    assign do_push = wr_en && (!full || do_pop);

    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    assign rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
// 8N1 UART receiver (oversampled, mid-bit sampling, glitch-rejecting) feeding a show-ahead byte FIFO.
// Byte visible 1 clk after the mid-stop-bit tick; a full FIFO drops the byte and raises sticky overrun.
module uart_rx_fifo #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       full,
    output logic       frame_err,
    output logic       overrun,
    input  logic       clr_err,
    output logic       rx_busy
);
    import uart_rx_fifo_pkg::*;

    localparam int TICK_DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int TICK_DIV     = (TICK_DIV_RAW < 1) ? 1 : TICK_DIV_RAW;
    localparam int DIV_W        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int OS_W         = $clog2(OVERSAMPLE);
    localparam int BIT_W        = $clog2(UART_DATA_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_DATA_W - 1);

    logic                   rx_meta_q, rx_s_q;
    logic [DIV_W-1:0]       div_q, div_d;
    logic                   tick;
    uart_state_e            state_q, state_d;
    logic [OS_W-1:0]        os_cnt_q, os_cnt_d;
    logic [BIT_W-1:0]       bit_idx_q, bit_idx_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   byte_ok, byte_bad, ovr_set;

    assign tick  = (div_q == DIV_LAST);
    assign div_d = tick ? '0 : div_q + DIV_W'(1);

    always_comb begin
        state_d   = state_q;
        os_cnt_d  = os_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_ok   = 1'b0;
        byte_bad  = 1'b0;
        if (tick) begin
            case (state_q)
                UART_IDLE: begin
                    if (!rx_s_q) begin
                        state_d  = UART_START;
                        os_cnt_d = '0;
                    end
                end
                UART_START: begin
                    if (os_cnt_q == OS_MID) begin
                        if (rx_s_q) begin
                            state_d = UART_IDLE;
                        end else begin
                            state_d   = UART_DATA;
                            os_cnt_d  = '0;
                            bit_idx_d = '0;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + OS_W'(1);
                    end
                end
                UART_DATA: begin
                    if (os_cnt_q == OS_LAST) begin
                        shift_d   = {rx_s_q, shift_q[UART_DATA_W-1:1]};
                        os_cnt_d  = '0;
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                        if (bit_idx_q == BIT_LAST) begin
                            state_d = UART_STOP;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + OS_W'(1);
                    end
                end
                UART_STOP: begin
                    // Leaving at mid-stop lets a back-to-back start edge be caught.
                    if (os_cnt_q == OS_LAST) begin
                        byte_ok  = rx_s_q;
                        byte_bad = !rx_s_q;
                        state_d  = UART_IDLE;
                        os_cnt_d = '0;
                    end else begin
                        os_cnt_d = os_cnt_q + OS_W'(1);
                    end
                end
                default: state_d = UART_IDLE;
            endcase
        end
    end

    // A same-clk pop makes room, so a byte arriving then is not an overrun.
    assign ovr_set     = byte_ok && full && !rd_en;
    assign frame_err_d = byte_bad || (frame_err_q && !clr_err);
    assign overrun_d   = ovr_set  || (overrun_q   && !clr_err);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            div_q       <= '0;
            state_q     <= UART_IDLE;
            os_cnt_q    <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx_in;
            rx_s_q      <= rx_meta_q;
            div_q       <= div_d;
            state_q     <= state_d;
            os_cnt_q    <= os_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    byte_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (byte_ok),
        .wr_data (shift_q),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full)
    );

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign rx_busy   = (state_q != UART_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
// Bench for uart_rx_fifo: 100 MHz clock, line rate scaled so one bit is 64 clocks (TICK_DIV=4, 16x).
module tb_uart_rx_fifo;
    localparam int  CLK_HZ = 100_000_000;
    localparam int  BAUD   = 1_562_500;
    localparam int  OS     = 16;
    localparam int  DEPTH  = 16;
    localparam real BIT_NS = 640.0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         pct;
        logic       exp_push;
        logic       exp_ferr;
    } vec_t;

    logic       clk = 1'b0, rst = 1'b1, rx_in = 1'b1, rd_en = 1'b0, clr_err = 1'b0;
    logic [7:0] rd_data;
    logic       empty, full, frame_err, overrun, rx_busy;

    int         n_checks = 0, n_errors = 0;
    logic [7:0] sb_q[$];
    int         fall_cnt = 0, busy_cnt = 0;
    realtime    t_fall = 0.0;

    uart_rx_fifo #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .rd_en(rd_en), .rd_data(rd_data),
        .empty(empty), .full(full), .frame_err(frame_err), .overrun(overrun),
        .clr_err(clr_err), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    always @(negedge empty) begin
        fall_cnt++;
        t_fall = $realtime;
    end

    always @(negedge clk) if (rx_busy === 1'b1) busy_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop, input real bit_ns, input int nbits);
        logic [9:0] fr;
        fr = {stop, data, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rx_in = fr[i];
            #(bit_ns);
        end
        rx_in = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        #(BIT_NS * n);
        @(negedge clk);
    endtask

    task automatic read_pop(input string name);
        int         t;
        logic [7:0] exp;
        t = 0;
        while (empty !== 1'b0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        if (empty !== 1'b0) begin
            check({name, "_timeout_empty"}, {31'd0, empty}, 32'd0);
        end else if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: byte %0h with no expected entry", name, rd_data);
        end else begin
            exp = sb_q.pop_front();
            check(name, {24'd0, rd_data}, {24'd0, exp});
        end
        rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        vec_t    vecs[7];
        string   hello;
        int      f0, b0;
        realtime t0, lat;

        vecs[0] = '{8'h00, 1'b1, 100, 1'b1, 1'b0};
        vecs[1] = '{8'hFF, 1'b1,  98, 1'b1, 1'b0};
        vecs[2] = '{8'hA5, 1'b1, 102, 1'b1, 1'b0};
        vecs[3] = '{8'h55, 1'b0, 100, 1'b0, 1'b1};
        vecs[4] = '{8'h5A, 1'b1,  98, 1'b1, 1'b0};
        vecs[5] = '{8'h81, 1'b1, 102, 1'b1, 1'b0};
        vecs[6] = '{8'h55, 1'b1, 100, 1'b1, 1'b0};

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_rd_data",   {24'd0, rd_data},   32'd0);
        check("rst_empty",     {31'd0, empty},     32'd1);
        check("rst_full",      {31'd0, full},      32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_overrun",   {31'd0, overrun},   32'd0);
        check("rst_rx_busy",   {31'd0, rx_busy},   32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle_bits(2);

        // Single byte: one empty fall, 9.5 bits plus sync/tick alignment after the start edge.
        f0 = fall_cnt;
        t0 = $realtime;
        sb_q.push_back(8'h48);
        send_frame(8'h48, 1'b1, BIT_NS, 10);
        idle_bits(1);
        check("t1_empty_falls", fall_cnt - f0, 32'd1);
        lat = t_fall - t0;
        n_checks++;
        if (lat < 6095.0 || lat > 6145.0) begin
            n_errors++;
            $display("FAIL t1_latency: empty fell %0.1f ns after start edge, expected 6100..6140", lat);
        end
        read_pop("t1_data");
        @(negedge clk);
        check("t1_empty_after_read", {31'd0, empty}, 32'd1);

        // Back-to-back "Hello World"
        hello = "Hello World";
        f0 = fall_cnt;
        for (int i = 0; i < hello.len(); i++) begin
            sb_q.push_back(hello[i]);
            send_frame(hello[i], 1'b1, BIT_NS, 10);
        end
        idle_bits(1);
        check("t2_full",         {31'd0, full},  32'd0);
        check("t2_empty",        {31'd0, empty}, 32'd0);
        check("t2_empty_falls",  fall_cnt - f0,  32'd1);
        for (int i = 0; i < 11; i++) read_pop("t2_data");
        @(negedge clk);
        check("t2_empty_after_drain", {31'd0, empty}, 32'd1);

        // Short low pulse (quarter bit) is rejected at mid-start
        b0 = busy_cnt;
        rx_in = 1'b0;
        #(BIT_NS / 4.0);
        rx_in = 1'b1;
        idle_bits(2);
        check("t3_busy_seen",  {31'd0, (busy_cnt != b0)}, 32'd1);
        check("t3_rx_busy",    {31'd0, rx_busy},   32'd0);
        check("t3_empty",      {31'd0, empty},     32'd1);
        check("t3_frame_err",  {31'd0, frame_err}, 32'd0);
        check("t3_overrun",    {31'd0, overrun},   32'd0);

        // Table: data patterns, baud +/-2%, bad stop bit
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].exp_push) sb_q.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop, BIT_NS * vecs[i].pct / 100.0, 10);
            idle_bits(1);
            check($sformatf("vec%0d_frame_err", i), {31'd0, frame_err}, {31'd0, vecs[i].exp_ferr});
            check($sformatf("vec%0d_empty", i),     {31'd0, empty},     {31'd0, !vecs[i].exp_push});
            if (vecs[i].exp_push) read_pop($sformatf("vec%0d_data", i));
            if (vecs[i].exp_ferr) begin
                pulse_clr();
                check($sformatf("vec%0d_ferr_cleared", i), {31'd0, frame_err}, 32'd0);
            end
        end

        // Overrun: 17 bytes into 16 entries, no reads
        for (int i = 0; i < 17; i++) begin
            if (i < DEPTH) sb_q.push_back(8'(i * 13 + 7));
            send_frame(8'(i * 13 + 7), 1'b1, BIT_NS, 10);
        end
        idle_bits(1);
        check("t5_full",      {31'd0, full},      32'd1);
        check("t5_overrun",   {31'd0, overrun},   32'd1);
        check("t5_frame_err", {31'd0, frame_err}, 32'd0);
        for (int i = 0; i < DEPTH; i++) read_pop("t5_data");
        @(negedge clk);
        check("t5_empty_after_drain", {31'd0, empty}, 32'd1);
        check("t5_full_after_drain",  {31'd0, full},  32'd0);
        pulse_clr();
        check("t5_overrun_cleared", {31'd0, overrun}, 32'd0);
        rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
        @(negedge clk);
        check("t5_pop_empty_ignored", {31'd0, empty},   32'd1);
        check("t5_rd_data_empty",     {24'd0, rd_data}, 32'd0);

        // Reset in the middle of 0xA5's data bits, then a clean 0x3C
        send_frame(8'hA5, 1'b1, BIT_NS, 5);
        @(negedge clk);
        check("t6_busy_mid_frame", {31'd0, rx_busy}, 32'd1);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle_bits(2);
        check("t6_empty_after_rst", {31'd0, empty},   32'd1);
        check("t6_busy_after_rst",  {31'd0, rx_busy}, 32'd0);
        sb_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, BIT_NS, 10);
        idle_bits(1);
        check("t6_frame_err", {31'd0, frame_err}, 32'd0);
        check("t6_overrun",   {31'd0, overrun},   32'd0);
        read_pop("t6_data");
        @(negedge clk);
        check("t6_empty_final", {31'd0, empty}, 32'd1);
        check("t6_sb_drained",  sb_q.size(),    32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
